// File: rtl/pipe_pkg.sv
// Shared pipeline widths, payload typedefs and stage occupancy codes.
package pipe_pkg;

  localparam int IF_ID_W        = 64;
  localparam int IF_ID_CTRL_W   = 0;
  localparam int ID_EX_W        = 150;
  localparam int ID_EX_CTRL_W   = 8;
  localparam int EX_MEM_W       = 105;
  localparam int EX_MEM_CTRL_W  = 4;
  localparam int MEM_WB_W       = 53;
  localparam int MEM_WB_CTRL_W  = 2;

  typedef logic [IF_ID_W-1:0]  if_id_t;
  typedef logic [ID_EX_W-1:0]  id_ex_t;
  typedef logic [EX_MEM_W-1:0] ex_mem_t;
  typedef logic [MEM_WB_W-1:0] mem_wb_t;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_TWO   = 2'd2;

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One-entry overflow register for pipe_stage (pipe_skid_slot).
module pipe_skid_slot #(
  parameter int WIDTH = 53
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             unload,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register with flush; define PIPE_STAGE_SKID_EN
// to add a one-entry skid slot and a registered IReady.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH  = MEM_WB_W,
  parameter int CTRL_W = MEM_WB_CTRL_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             IValid,
  output logic             IReady,
  input  logic [WIDTH-1:0] IData,
  input  logic             Flush,
  output logic             OValid,
  input  logic             OReady,
  output logic [WIDTH-1:0] OData,
  output logic [1:0]       OCount
);

  localparam logic [WIDTH-1:0] CTRL_MASK =
    ~({WIDTH{1'b1}} << CTRL_W);

  logic             ovalid;
  logic [WIDTH-1:0] odata;
  logic             accept;
  logic             emit;
  logic             load_main;
  logic             drop;
  logic [WIDTH-1:0] main_d;

  assign accept = IValid & IReady;
  assign emit   = ovalid & OReady;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_load;
  logic             skid_unload;

  assign IReady      = !skid_valid;
  assign skid_load   = accept & ovalid & !emit;
  assign skid_unload = emit & skid_valid;

  pipe_skid_slot #(.WIDTH(WIDTH)) u_skid (
    .clk    (CLK),
    .rst    (Reset),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (Flush),
    .d      (IData),
    .q      (skid_data),
    .valid  (skid_valid)
  );

  // Skid content is older than any incoming beat, so it refills first.
  assign load_main = (emit & skid_valid)
                   | (accept & (!ovalid | emit));
  assign main_d    = skid_valid ? skid_data : IData;
  assign drop      = emit & !skid_valid & !accept;

  always_comb begin
    OCount = CNT_EMPTY;
    unique case (1'b1)
      skid_valid: OCount = CNT_TWO;
      ovalid:     OCount = CNT_ONE;
      default:    OCount = CNT_EMPTY;
    endcase
  end
`else
  assign IReady    = !ovalid | OReady;
  assign load_main = accept;
  assign main_d    = IData;
  assign drop      = emit & !accept;
  assign OCount    = ovalid ? CNT_ONE : CNT_EMPTY;
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ovalid <= 1'b0;
      odata  <= '0;
    end else if (Flush) begin
      ovalid <= 1'b0;
      odata  <= odata & ~CTRL_MASK;
    end else if (load_main) begin
      ovalid <= 1'b1;
      odata  <= main_d;
    end else if (drop) begin
      ovalid <= 1'b0;
    end
  end

  assign OValid = ovalid;
  assign OData  = odata;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: vector table plus backpressure,
// skid, flush and reset sequences (skid checks follow PIPE_STAGE_SKID_EN).
module tb_pipe_stage;
  import pipe_pkg::*;

  localparam int W = MEM_WB_W;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         IValid;
  logic         IReady;
  logic [W-1:0] IData;
  logic         Flush;
  logic         OValid;
  logic         OReady;
  logic [W-1:0] OData;
  logic [1:0]   OCount;

  int n_pass = 0;
  int n_total = 0;

  pipe_stage #(.WIDTH(W), .CTRL_W(MEM_WB_CTRL_W)) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .IValid (IValid),
    .IReady (IReady),
    .IData  (IData),
    .Flush  (Flush),
    .OValid (OValid),
    .OReady (OReady),
    .OData  (OData),
    .OCount (OCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         ir;
    logic         ov;
    logic [W-1:0] od;
    logic [1:0]   cnt;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(logic iv, logic [W-1:0] d,
                              logic ordy, logic fl, logic ir,
                              logic ov, logic [W-1:0] od,
                              logic [1:0] cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ir = ir; v.ov = ov; v.od = od; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(logic iv, logic [W-1:0] d, logic ordy, logic fl);
    IValid = iv;
    IData  = d;
    OReady = ordy;
    Flush  = fl;
  endtask

  task automatic post_edge(string tag, logic ov, logic [W-1:0] od,
                           logic [1:0] cnt);
    @(posedge CLK);
    #1;
    chk({tag, ".ov"}, 64'(OValid), 64'(ov));
    chk({tag, ".od"}, 64'(OData), 64'(od));
    chk({tag, ".cnt"}, 64'(OCount), 64'(cnt));
  endtask

  localparam logic [W-1:0] RST_D = 53'h1_5678_9abc_1234_3;
  localparam logic [W-1:0] B1 = 53'h0_1111_0000_0001;
  localparam logic [W-1:0] B2 = 53'h0_1111_0000_0002;
  localparam logic [W-1:0] B3 = 53'h0_1111_0000_0003;
  localparam logic [W-1:0] B4 = 53'h0_1111_0000_0004;
  localparam logic [W-1:0] BD = 53'h1_abcd_0123_4567;
  localparam logic [W-1:0] BDM = 53'h1_abcd_0123_4564;
  localparam logic [W-1:0] BC = 53'h0_0000_0000_0c0f;
  localparam logic [W-1:0] B5 = 53'h0_2222_0000_0005;
  localparam logic [W-1:0] BA = 53'h0_aaaa_aaaa_aaab;
  localparam logic [W-1:0] BB = 53'h0_bbbb_bbbb_bbbb;
  localparam logic [W-1:0] BE = 53'h1_eeee_eeee_eeee;

  initial begin
    Reset = 1'b1;
    drive(1'b1, RST_D, 1'b1, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.ov", 64'(OValid), 64'd0);
    chk("rst.od", 64'(OData), 64'd0);
    chk("rst.cnt", 64'(OCount), 64'd0);
    chk("rst.ir", 64'(IReady), 64'd1);
    @(negedge CLK);
    Reset = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0);

    tbl[0] = mk(1, B1, 1, 0, 1, 1, B1, CNT_ONE);
    tbl[1] = mk(1, B2, 1, 0, 1, 1, B2, CNT_ONE);
    tbl[2] = mk(1, B3, 1, 0, 1, 1, B3, CNT_ONE);
    tbl[3] = mk(1, B4, 1, 0, 1, 1, B4, CNT_ONE);
    tbl[4] = mk(0, '0, 1, 0, 1, 0, B4, CNT_EMPTY);
    tbl[5] = mk(1, BD, 1, 0, 1, 1, BD, CNT_ONE);
    tbl[6] = mk(1, BC, 1, 1, 1, 0, BDM, CNT_EMPTY);
    tbl[7] = mk(0, '0, 1, 0, 1, 0, BDM, CNT_EMPTY);
    tbl[8] = mk(1, B5, 1, 0, 1, 1, B5, CNT_ONE);
    tbl[9] = mk(0, '0, 1, 0, 1, 0, B5, CNT_EMPTY);

    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      #1;
      chk($sformatf("vec%0d.ir", i), 64'(IReady), 64'(tbl[i].ir));
      post_edge($sformatf("vec%0d", i), tbl[i].ov, tbl[i].od,
                tbl[i].cnt);
    end

    // asynchronous reset in mid-cycle while holding a beat
    @(negedge CLK);
    drive(1'b1, 53'h7, 1'b0, 1'b0);
    post_edge("mrst.pre", 1'b1, 53'h7, CNT_ONE);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    chk("mrst.ov", 64'(OValid), 64'd0);
    chk("mrst.od", 64'(OData), 64'd0);
    chk("mrst.cnt", 64'(OCount), 64'd0);
    chk("mrst.ir", 64'(IReady), 64'd1);
    @(negedge CLK);
    Reset = 1'b0;

    // flush and reset together act as reset
    @(negedge CLK);
    drive(1'b1, BD, 1'b0, 1'b0);
    post_edge("fr.pre", 1'b1, BD, CNT_ONE);
    @(negedge CLK);
    drive(1'b1, BC, 1'b0, 1'b1);
    Reset = 1'b1;
    post_edge("fr", 1'b0, '0, CNT_EMPTY);
    @(negedge CLK);
    Reset = 1'b0;
    drive(1'b1, B5, 1'b1, 1'b0);
    post_edge("fr.next", 1'b1, B5, CNT_ONE);
    @(negedge CLK);
    drive(1'b0, '0, 1'b1, 1'b0);
    post_edge("fr.drain", 1'b0, B5, CNT_EMPTY);

`ifdef PIPE_STAGE_SKID_EN
    @(negedge CLK);
    drive(1'b1, BA, 1'b0, 1'b0);
    post_edge("sk.a", 1'b1, BA, CNT_ONE);
    @(negedge CLK);
    drive(1'b1, BB, 1'b0, 1'b0);
    #1;
    chk("sk.ir_b", 64'(IReady), 64'd1);
    post_edge("sk.b", 1'b1, BA, CNT_TWO);
    chk("sk.ir_full", 64'(IReady), 64'd0);
    @(negedge CLK);
    drive(1'b0, '0, 1'b1, 1'b0);
    post_edge("sk.emit_a", 1'b1, BB, CNT_ONE);
    chk("sk.ir_free", 64'(IReady), 64'd1);
    post_edge("sk.emit_b", 1'b0, BB, CNT_EMPTY);

    @(negedge CLK);
    drive(1'b1, BA, 1'b0, 1'b0);
    post_edge("skf.a", 1'b1, BA, CNT_ONE);
    @(negedge CLK);
    drive(1'b1, BB, 1'b0, 1'b0);
    post_edge("skf.b", 1'b1, BA, CNT_TWO);
    @(negedge CLK);
    drive(1'b1, BC, 1'b0, 1'b1);
    post_edge("skf.flush", 1'b0, BA & ~53'h3, CNT_EMPTY);
    chk("skf.ir", 64'(IReady), 64'd1);
    @(negedge CLK);
    drive(1'b1, BE, 1'b1, 1'b0);
    post_edge("skf.next", 1'b1, BE, CNT_ONE);
    @(negedge CLK);
    drive(1'b0, '0, 1'b1, 1'b0);
    post_edge("skf.drain", 1'b0, BE, CNT_EMPTY);
`else
    @(negedge CLK);
    drive(1'b1, BA, 1'b0, 1'b0);
    post_edge("bp.a", 1'b1, BA, CNT_ONE);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      drive(1'b1, BB, 1'b0, 1'b0);
      #1;
      chk($sformatf("bp.ir%0d", k), 64'(IReady), 64'd0);
      post_edge($sformatf("bp.hold%0d", k), 1'b1, BA, CNT_ONE);
    end
    @(negedge CLK);
    drive(1'b1, BB, 1'b1, 1'b0);
    #1;
    chk("bp.ir_rel", 64'(IReady), 64'd1);
    post_edge("bp.b", 1'b1, BB, CNT_ONE);
    @(negedge CLK);
    drive(1'b0, '0, 1'b1, 1'b0);
    post_edge("bp.drain", 1'b0, BB, CNT_EMPTY);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
